// File: rtl/ram16k_arbiter.sv
// Two-port arbiter in front of a single-port RAM16K: port 0 (CPU) has priority,
// port 1 (DMA/IO) is protected from starvation and may lock the RAM for short bursts.
module ram16k_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,

  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic {ARB, LOCK1} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  state_t     state, state_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic [7:0] lock_cnt, lock_nx;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = state;
    lock_nx  = lock_cnt;

    unique case (state)
      ARB: begin
        if (req1 && wait_cnt == WAIT_LIMIT) gnt1 = 1'b1;
        else if (req0)                      gnt0 = 1'b1;
        else if (req1)                      gnt1 = 1'b1;
        // A single-grant lock limit is exhausted by this grant, so stay in ARB.
        if (gnt1 && lock1 && MAX_LOCK > 1) begin
          state_nx = LOCK1;
          lock_nx  = 8'd1;
        end
      end
      LOCK1: begin
        if (req1) begin
          gnt1    = 1'b1;
          lock_nx = lock_cnt + 8'd1;
          if (!lock1 || lock_nx == LOCK_LIMIT) begin
            state_nx = ARB;
            lock_nx  = 8'd0;
          end
        end else begin
          // Port 1 went idle: port 0 is served this very cycle.
          gnt0     = req0;
          state_nx = ARB;
          lock_nx  = 8'd0;
        end
      end
      default: begin
        state_nx = ARB;
        lock_nx  = 8'd0;
      end
    endcase

    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    if (!req1 || gnt1)             wait_nx = 4'd0;
    else if (wait_cnt < WAIT_LIMIT) wait_nx = wait_cnt + 4'd1;
    else                           wait_nx = wait_cnt;
  end

  always_comb begin
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    if (gnt0) begin
      mem_load    = we0;
      mem_address = addr0;
      mem_in      = wdata0;
    end else if (gnt1) begin
      mem_load    = we1;
      mem_address = addr1;
      mem_in      = wdata1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      wait_cnt <= 4'd0;
      lock_cnt <= 8'd0;
      rdata0   <= '0;
      rdata1   <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      lock_cnt <= lock_nx;
      rvalid0  <= gnt0 && !we0;
      rvalid1  <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_out;
      if (gnt1 && !we1) rdata1 <= mem_out;
    end
  end

endmodule
